// File: rtl/bp_pkg.sv
// bp_pkg: shared constants, field widths, FSM states and counter helpers for the branch predictor
package bp_pkg;

    localparam int BP_BIMODAL = 0;
    localparam int BP_GSHARE  = 1;
    localparam int BP_LOCAL   = 2;

    localparam logic [1:0] CTR_INIT = 2'b01;

    typedef enum logic {INIT, RUN} bp_state_e;

    function automatic int bp_tag_w(input int dbits, input int idx_bits);
        return dbits - idx_bits - 2;
    endfunction

    function automatic int bp_entry_w(input int dbits, input int idx_bits);
        return 2 + bp_tag_w(dbits, idx_bits) + dbits;
    endfunction

    function automatic int bp_max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

    function automatic logic [1:0] bp_sat(input logic [1:0] c, input logic up);
        return up ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
    endfunction

endpackage

// File: rtl/bp_btb.sv
// bp_btb: tagged direct-mapped branch target buffer with one lookup, one write and one clear port
module bp_btb
    import bp_pkg::*;
#(
    parameter int DBITS    = 32,
    parameter int IDX_BITS = 4
) (
    input  logic                clk,
    input  logic [DBITS-1:0]    rd_pc_i,
    output logic                rd_hit_o,
    output logic                rd_is_cond_o,
    output logic [DBITS-1:0]    rd_target_o,
    input  logic                wr_en_i,
    input  logic [DBITS-1:0]    wr_pc_i,
    input  logic                wr_is_cond_i,
    input  logic [DBITS-1:0]    wr_target_i,
    input  logic                clr_en_i,
    input  logic [IDX_BITS-1:0] clr_idx_i
);

    localparam int TAG_W   = bp_tag_w(DBITS, IDX_BITS);
    localparam int ENTRY_W = bp_entry_w(DBITS, IDX_BITS);
    localparam int N       = 1 << IDX_BITS;

    typedef struct packed {
        logic             valid;
        logic             is_cond;
        logic [TAG_W-1:0] tag;
        logic [DBITS-1:0] target;
    } btb_entry_t;

    btb_entry_t          tbl_q [N];
    btb_entry_t          rd_e;
    btb_entry_t          wr_e;
    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;

    assign rd_idx       = rd_pc_i[IDX_BITS+1:2];
    assign wr_idx       = wr_pc_i[IDX_BITS+1:2];
    assign rd_e         = tbl_q[rd_idx];
    assign rd_hit_o     = rd_e.valid && (rd_e.tag == rd_pc_i[DBITS-1:IDX_BITS+2]);
    assign rd_is_cond_o = rd_e.is_cond;
    assign rd_target_o  = rd_e.target;
    assign wr_e         = btb_entry_t'({1'b1, wr_is_cond_i, wr_pc_i[DBITS-1:IDX_BITS+2], wr_target_i});

    // Init sweep invalidates one entry per cycle; otherwise a taken branch installs its entry
    always_ff @(posedge clk) begin
        if (clr_en_i)
            tbl_q[clr_idx_i].valid <= 1'b0;
        else if (wr_en_i)
            tbl_q[wr_idx] <= wr_e[ENTRY_W-1:0];
    end

endmodule

// File: rtl/branch_pred_unit.sv
// branch_pred_unit: BTB plus bimodal/gshare/local direction predictor with init sweep and accuracy stats
module branch_pred_unit
    import bp_pkg::*;
#(
    parameter int DBITS        = 32,
    parameter int MODE         = 1,
    parameter int PHT_IDX_BITS = 8,
    parameter int BTB_IDX_BITS = 4,
    parameter int LHT_IDX_BITS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] pc_FE,
    input  logic [DBITS-1:0] pcplus_FE,
    output logic [DBITS-1:0] predicted_pc_FE,
    output logic             pred_taken_FE,
    output logic             ready,
    input  logic             upd_valid_AGEX,
    input  logic             upd_is_cond_AGEX,
    input  logic             upd_taken_AGEX,
    input  logic             upd_mispred_AGEX,
    input  logic [DBITS-1:0] upd_pc_AGEX,
    input  logic [DBITS-1:0] upd_target_AGEX,
    output logic [31:0]      stat_total,
    output logic [31:0]      stat_correct
);

    localparam int PB       = PHT_IDX_BITS;
    localparam int LB       = LHT_IDX_BITS;
    localparam int CNT_BITS = bp_max3(PHT_IDX_BITS, BTB_IDX_BITS, LHT_IDX_BITS);
    localparam int PHT_N    = 1 << PHT_IDX_BITS;
    localparam int BTB_N    = 1 << BTB_IDX_BITS;
    localparam int LHT_N    = 1 << LHT_IDX_BITS;

    bp_state_e           state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q;
    logic [PB-1:0]       ghr_q;
    logic [1:0]          pht_q [PHT_N];
    logic [PB-1:0]       lht_q [LHT_N];
    logic [31:0]         stat_total_q, stat_correct_q;
    logic                init, upd, upd_cond;
    logic [PB-1:0]       fe_idx, ag_idx;
    logic                btb_hit, btb_cond;
    logic [DBITS-1:0]    btb_tgt;

    assign init     = state_q == INIT;
    assign ready    = state_q == RUN;
    assign upd      = upd_valid_AGEX && ready;
    assign upd_cond = upd && upd_is_cond_AGEX;

    assign fe_idx = (MODE == BP_GSHARE) ? (pc_FE[PB+1:2] ^ ghr_q)
                  : (MODE == BP_LOCAL)  ? lht_q[pc_FE[LB+1:2]]
                  :                       pc_FE[PB+1:2];
    assign ag_idx = (MODE == BP_GSHARE) ? (upd_pc_AGEX[PB+1:2] ^ ghr_q)
                  : (MODE == BP_LOCAL)  ? lht_q[upd_pc_AGEX[LB+1:2]]
                  :                       upd_pc_AGEX[PB+1:2];

    bp_btb #(
        .DBITS    (DBITS),
        .IDX_BITS (BTB_IDX_BITS)
    ) u_btb (
        .clk          (clk),
        .rd_pc_i      (pc_FE),
        .rd_hit_o     (btb_hit),
        .rd_is_cond_o (btb_cond),
        .rd_target_o  (btb_tgt),
        .wr_en_i      (upd && upd_taken_AGEX),
        .wr_pc_i      (upd_pc_AGEX),
        .wr_is_cond_i (upd_is_cond_AGEX),
        .wr_target_i  (upd_target_AGEX),
        .clr_en_i     (init && (int'(cnt_q) < BTB_N)),
        .clr_idx_i    (cnt_q[BTB_IDX_BITS-1:0])
    );

    assign pred_taken_FE   = ready && btb_hit && (!btb_cond || pht_q[fe_idx][1]);
    assign predicted_pc_FE = pred_taken_FE ? btb_tgt : pcplus_FE;
    assign stat_total      = stat_total_q;
    assign stat_correct    = stat_correct_q;

    // Leave INIT once the sweep has written the last index of the largest table
    always_comb begin
        state_d = (init && (cnt_q == '1)) ? RUN : state_q;
    end

    // State register and sweep counter; reset always restarts the sweep from index 0
    always_ff @(posedge clk) begin
        state_q <= reset ? INIT : state_d;
        cnt_q   <= reset ? '0 : init ? cnt_q + CNT_BITS'(1) : cnt_q;
    end

    // Direction counters: weakly not-taken during the sweep, saturating training afterwards
    always_ff @(posedge clk) begin
        if (init) begin
            if (int'(cnt_q) < PHT_N)
                pht_q[cnt_q[PB-1:0]] <= CTR_INIT;
        end else if (upd_cond) begin
            pht_q[ag_idx] <= bp_sat(pht_q[ag_idx], upd_taken_AGEX);
        end
    end

    // Global history only advances on resolved conditional branches in gshare mode
    always_ff @(posedge clk) begin
        if (reset)
            ghr_q <= '0;
        else if (upd_cond && (MODE == BP_GSHARE))
            ghr_q <= {ghr_q[PB-2:0], upd_taken_AGEX};
    end

    // Per-branch local histories, cleared by the sweep and shifted in local mode
    always_ff @(posedge clk) begin
        if (init) begin
            if (int'(cnt_q) < LHT_N)
                lht_q[cnt_q[LB-1:0]] <= '0;
        end else if (upd_cond && (MODE == BP_LOCAL)) begin
            lht_q[upd_pc_AGEX[LB+1:2]] <= {lht_q[upd_pc_AGEX[LB+1:2]][PB-2:0], upd_taken_AGEX};
        end
    end

    // Accuracy counters over every resolved jump/branch seen while ready
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_total_q   <= '0;
            stat_correct_q <= '0;
        end else if (upd) begin
            stat_total_q   <= stat_total_q + 32'd1;
            stat_correct_q <= stat_correct_q + {31'd0, !upd_mispred_AGEX};
        end
    end

endmodule

// File: tb/tb_branch_pred_unit.sv
// tb_branch_pred_unit: three predictor modes driven in lockstep against a table-level reference model
module tb_branch_pred_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_FE, pcplus_FE, upd_pc_AGEX, upd_target_AGEX;
    logic        upd_valid_AGEX, upd_is_cond_AGEX, upd_taken_AGEX, upd_mispred_AGEX;
    logic [31:0] ppc  [3];
    logic        ptk  [3];
    logic        rdy  [3];
    logic [31:0] stot [3];
    logic [31:0] scor [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        branch_pred_unit #(.MODE(g)) dut (
            .clk              (clk),
            .reset            (reset),
            .pc_FE            (pc_FE),
            .pcplus_FE        (pcplus_FE),
            .predicted_pc_FE  (ppc[g]),
            .pred_taken_FE    (ptk[g]),
            .ready            (rdy[g]),
            .upd_valid_AGEX   (upd_valid_AGEX),
            .upd_is_cond_AGEX (upd_is_cond_AGEX),
            .upd_taken_AGEX   (upd_taken_AGEX),
            .upd_mispred_AGEX (upd_mispred_AGEX),
            .upd_pc_AGEX      (upd_pc_AGEX),
            .upd_target_AGEX  (upd_target_AGEX),
            .stat_total       (stot[g]),
            .stat_correct     (scor[g])
        );
    end

    int          m_pht [3][256];
    int          m_ghr;
    int          m_lht [64];
    bit          m_bv  [16];
    bit          m_bc  [16];
    logic [31:0] m_btag [16];
    logic [31:0] m_btgt [16];
    int          m_init;
    int unsigned m_tot, m_cor;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic int pidx(input int m, input logic [31:0] pc);
        int base = int'((pc >> 2) % 256);
        if (m == 1) return base ^ m_ghr;
        if (m == 2) return m_lht[int'((pc >> 2) % 64)];
        return base;
    endfunction

    function automatic bit ptaken(input int m, input logic [31:0] pc);
        int b = int'((pc >> 2) % 16);
        if (m_init != 0) return 1'b0;
        if (!m_bv[b] || m_btag[b] != (pc >> 6)) return 1'b0;
        return !m_bc[b] || m_pht[m][pidx(m, pc)] >= 2;
    endfunction

    function automatic logic [31:0] ppred(input int m, input logic [31:0] pc);
        return ptaken(m, pc) ? m_btgt[int'((pc >> 2) % 16)] : pc + 32'd4;
    endfunction

    task automatic model_step(input bit r, input bit uv, input bit uc, input bit ut, input bit um,
                              input logic [31:0] upc, input logic [31:0] utg);
        int ix [3];
        int l;
        int b;
        if (r) begin
            for (int m = 0; m < 3; m++) for (int i = 0; i < 256; i++) m_pht[m][i] = 1;
            for (int i = 0; i < 64; i++) m_lht[i] = 0;
            for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
            m_ghr = 0; m_tot = 0; m_cor = 0; m_init = 256;
            return;
        end
        if (m_init > 0) begin
            m_init--;
            return;
        end
        if (!uv) return;
        m_tot++;
        if (!um) m_cor++;
        if (uc) begin
            for (int m = 0; m < 3; m++) ix[m] = pidx(m, upc);
            for (int m = 0; m < 3; m++)
                m_pht[m][ix[m]] = ut ? ((m_pht[m][ix[m]] == 3) ? 3 : m_pht[m][ix[m]] + 1)
                                     : ((m_pht[m][ix[m]] == 0) ? 0 : m_pht[m][ix[m]] - 1);
            m_ghr = ((m_ghr << 1) | int'(ut)) & 255;
            l = int'((upc >> 2) % 64);
            m_lht[l] = ((m_lht[l] << 1) | int'(ut)) & 255;
        end
        if (ut) begin
            b = int'((upc >> 2) % 16);
            m_bv[b] = 1'b1; m_bc[b] = uc; m_btag[b] = upc >> 6; m_btgt[b] = utg;
        end
    endtask

    task automatic cyc(input bit r, input logic [31:0] pc, input bit uv, input bit uc, input bit ut,
                       input bit um, input logic [31:0] upc, input logic [31:0] utg);
        reset = r; pc_FE = pc; pcplus_FE = pc + 32'd4;
        upd_valid_AGEX = uv; upd_is_cond_AGEX = uc; upd_taken_AGEX = ut; upd_mispred_AGEX = um;
        upd_pc_AGEX = upc; upd_target_AGEX = utg;
        #3;
        if (!r) for (int m = 0; m < 3; m++) begin
            check($sformatf("m%0d_pred_pc", m), ppc[m], ppred(m, pc));
            check($sformatf("m%0d_pred_taken", m), {31'd0, ptk[m]}, {31'd0, ptaken(m, pc)});
            check($sformatf("m%0d_ready", m), {31'd0, rdy[m]}, {31'd0, m_init == 0});
            check($sformatf("m%0d_stat_total", m), stot[m], m_tot);
            check($sformatf("m%0d_stat_correct", m), scor[m], m_cor);
        end
        @(posedge clk);
        model_step(r, uv, uc, ut, um, upc, utg);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input bit c, input bit t, input logic [31:0] tgt);
        bit mis = ppred(1, pc) != (t ? tgt : pc + 32'd4);
        cyc(1'b0, pc, 1'b1, c, t, mis, pc, tgt);
    endtask

    task automatic idle(input logic [31:0] pc);
        cyc(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rst_cyc();
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic peek(input logic [31:0] pc);
        reset = 1'b0; upd_valid_AGEX = 1'b0; pc_FE = pc; pcplus_FE = pc + 32'd4;
        #2;
    endtask

    task automatic rnd_cyc();
        logic [31:0] pool [6] = '{32'h40, 32'h44, 32'h80, 32'h440, 32'h1040, 32'h8c};
        logic [31:0] upc = pool[$urandom_range(5)];
        logic [31:0] pc  = ($urandom_range(1) == 1) ? upc : pool[$urandom_range(5)];
        logic [31:0] tgt = 32'($urandom_range(1023)) << 2;
        bit uv = $urandom_range(3) != 0;
        bit uc = $urandom_range(3) != 0;
        bit ut = $urandom_range(1) == 1;
        bit um = ppred(1, upc) != (ut ? tgt : upc + 32'd4);
        cyc(1'b0, pc, uv, uc, ut, um, upc, tgt);
    endtask

    initial begin
        int n0;
        int nc;
        bit t;
        bit mis;
        reset = 1'b1; pc_FE = '0; pcplus_FE = 32'd4;
        upd_valid_AGEX = 1'b0; upd_is_cond_AGEX = 1'b0; upd_taken_AGEX = 1'b0; upd_mispred_AGEX = 1'b0;
        upd_pc_AGEX = '0; upd_target_AGEX = '0;
        @(posedge clk); #1;
        repeat (3) rst_cyc();

        n0 = 0;
        while (!rdy[0] && n0 < 1000) begin
            rnd_cyc();
            n0++;
        end
        check("init_length", n0, 256);

        repeat (2) train(32'h40, 1'b1, 1'b1, 32'h100);
        peek(32'h40);
        check("bimodal_taken", {31'd0, ptk[0]}, 32'd1);
        check("bimodal_target", ppc[0], 32'h100);
        repeat (2) train(32'h40, 1'b1, 1'b0, 32'h100);
        peek(32'h40);
        check("bimodal_not_taken", ppc[0], 32'h44);

        train(32'h80, 1'b0, 1'b1, 32'h200);
        peek(32'h80);
        for (int m = 0; m < 3; m++) check($sformatf("m%0d_jump", m), ppc[m], 32'h200);

        train(32'h440, 1'b1, 1'b1, 32'h300);
        peek(32'h40);
        for (int m = 0; m < 3; m++) check($sformatf("m%0d_alias_miss", m), ppc[m], 32'h44);

        repeat (300) rnd_cyc();

        repeat (2) rst_cyc();
        while (m_init > 0) rnd_cyc();
        nc = 0;
        for (int k = 0; k < 20; k++) begin
            t = (k % 2) == 0;
            peek(32'h40);
            if (k >= 12) check($sformatf("gshare_alt_%0d", k), {31'd0, ptk[1]}, {31'd0, t});
            mis = ppred(1, 32'h40) != (t ? 32'h500 : 32'h44);
            if (!mis) nc++;
            cyc(1'b0, 32'h40, 1'b1, 1'b1, t, mis, 32'h40, 32'h500);
        end
        peek(32'h40);
        check("gshare_total", stot[1], 32'd20);
        check("gshare_correct", scor[1], nc);

        repeat (2) rst_cyc();
        while (m_init > 0) idle(32'h80);
        repeat (5) train(32'h80, 1'b0, 1'b1, 32'h200);
        peek(32'h80);
        check("pre_reset_total", stot[0], 32'd5);
        check("pre_reset_pred", ppc[0], 32'h200);
        repeat (2) rst_cyc();
        peek(32'h80);
        check("post_reset_ready", {31'd0, rdy[0]}, 32'd0);
        check("post_reset_total", stot[0], 32'd0);
        check("post_reset_pred", ppc[0], 32'h84);
        while (m_init > 0) idle(32'h80);
        peek(32'h80);
        for (int m = 0; m < 3; m++) begin
            check($sformatf("m%0d_reinit_ready", m), {31'd0, rdy[m]}, 32'd1);
            check($sformatf("m%0d_btb_empty", m), ppc[m], 32'h84);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
